uart_msg_ctl: RTL and testbench

Byte-stream controller between the UART receiver and transmitter. It echoes received bytes through a parametrised FIFO, or it periodically transmits a parametrised message string. Unlike the first-generation controller, it uses a valid/ready handshake toward the transmitter, so no bytes are lost to backpressure. It sits between `uart_rx` and `uart_tx` in the top-level UART demo.

---
 rtl/uart_msg_ctl.sv | 173 +++++++++++++++++
 tb/tb_uart_msg_ctl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_msg_ctl                                                             |
// | Echoes UART rx bytes through a FIFO, or periodically sends a fixed       |
// | message, toward the transmitter over a valid/ready handshake.            |
// | Optional: UART_MSG_CTL_UPCASE_EN upper-cases echoed 'a'..'z'.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_msg_ctl #(
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   PERIOD     = 100000000,
  parameter int                   MSG_LEN    = 15,
  parameter logic [8*MSG_LEN-1:0] MSG        = "Hello, world!\r\n"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       ovf,
  output logic       busy
);

  localparam int               c_addr_w   = $clog2(FIFO_DEPTH);
  localparam int               c_cnt_w    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_addr_w:0] c_full    = (c_addr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_tc     = c_cnt_w'(PERIOD - 1);
  localparam logic [7:0]       c_last_idx = 8'(MSG_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_msg_load;
  logic [7:0]           r_idx;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_mode;
  logic                 r_rx_prev;
  logic [c_addr_w-1:0]  r_wptr;
  logic [c_addr_w-1:0]  r_rptr;
  logic [c_addr_w:0]    r_count;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_ovf;
  logic [7:0]           w_msg_rom [256];
  logic [7:0]           w_push_data;

  // Message bytes laid out first-character-first, indexed directly by r_idx.
  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    if (gi < MSG_LEN) begin : g_byte
      assign w_msg_rom[gi] = MSG[8*(MSG_LEN-1-gi) +: 8];
    end else begin : g_pad
      assign w_msg_rom[gi] = 8'h00;
    end
  end

`ifdef UART_MSG_CTL_UPCASE_EN
  assign w_push_data = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? (rx_data & 8'hDF) : rx_data;
`else
  assign w_push_data = rx_data;
`endif

  logic w_xfer, w_out_free, w_quiet, w_mode_nxt, w_enter_send, w_tc;
  logic w_rise, w_push_req, w_full, w_empty, w_pop, w_push, w_drop;

  assign w_xfer       = r_tx_valid & tx_ready;
  assign w_out_free   = ~r_tx_valid | tx_ready;
  assign w_quiet      = w_out_free && (r_state == S_IDLE);
  assign w_mode_nxt   = w_quiet ? mode : r_mode;
  assign w_enter_send = w_quiet & mode & ~r_mode;
  assign w_tc         = (r_cnt == c_tc);
  assign w_rise       = rx_valid & ~r_rx_prev;
  assign w_push_req   = w_rise & ~r_mode;
  assign w_full       = (r_count == c_full);
  assign w_empty      = (r_count == '0);
  assign w_pop        = ~r_mode & ~w_empty & w_out_free;
  assign w_push       = w_push_req & (~w_full | w_pop);
  assign w_drop       = w_push_req & w_full & ~w_pop;

  // A burst is only started if the active mode stays send through this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_msg_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_mode && w_mode_nxt && w_tc) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_out_free) begin
          w_msg_load = 1'b1;
          if (r_idx == c_last_idx) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 8'd0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_rx_prev <= rx_valid;
      if (r_state == S_IDLE)  r_idx <= 8'd0;
      else if (w_msg_load)    r_idx <= r_idx + 8'd1;
      if (!r_mode || w_tc)    r_cnt <= '0;
      else                    r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_enter_send) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  // Message loads and FIFO pops are mutually exclusive by active mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_msg_load) begin
      r_tx_data  <= w_msg_rom[r_idx];
      r_tx_valid <= 1'b1;
    end else if (w_pop) begin
      r_tx_data  <= r_mem[r_rptr];
      r_tx_valid <= 1'b1;
    end else if (w_xfer) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign ovf      = r_ovf;
  assign busy     = r_tx_valid | ~w_empty | (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_ctl.sv
`default_nettype none
// Scoreboard bench for uart_msg_ctl: stimulus queues expected tx bytes (with
// optional exact transfer cycle), a negedge monitor pops and compares them.
module tb_uart_msg_ctl;
  localparam int FIFO_DEPTH = 4;
  localparam int PERIOD     = 32;
  localparam int MSG_LEN    = 15;
  localparam logic [8*MSG_LEN-1:0] MSG = "Hello, world!\r\n";

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       mode     = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  wire  [7:0] tx_data;
  wire        tx_valid;
  wire        ovf;
  wire        busy;

  uart_msg_ctl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .PERIOD    (PERIOD),
    .MSG_LEN   (MSG_LEN),
    .MSG       (MSG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ovf     (ovf),
    .busy    (busy)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         n_xfer = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int i);
    logic [8*MSG_LEN-1:0] m;
    m = MSG;
    return m[8*(MSG_LEN-1-i) +: 8];
  endfunction

  function automatic logic [7:0] echo_exp(input logic [7:0] d);
`ifdef UART_MSG_CTL_UPCASE_EN
    if (d >= 8'h61 && d <= 8'h7A) return d & 8'hDF;
`endif
    return d;
  endfunction

  task automatic push_exp(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_pulse(input logic [7:0] d, input int hold);
    rx_data  = d;
    rx_valid = 1'b1;
    tick(hold);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int k = 0;
    while (n_xfer < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("xfer_budget", 32'(n_xfer >= target), 1);
  endtask

  // Monitor: a transfer is seen at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        chk("stall_hold", 32'({tx_valid, tx_data}), 32'({1'b1, stall_data}));
      if (tx_valid && tx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.data));
          if (e.cyc >= 0) chk("xfer_cycle", cyc, e.cyc);
        end
      end
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    logic prev_low;

    tick(3);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data",  32'(tx_data),  0);
    chk("rst_ovf",      32'(ovf),      0);
    chk("rst_busy",     32'(busy),     0);
    rst = 1'b0;
    tick(2);

    // Echo with latency stamps; last byte held high for several cycles.
    tx_ready = 1'b1;
    c = cyc; push_exp(echo_exp(8'h41), c + 2); rx_pulse(8'h41, 1);
    c = cyc; push_exp(echo_exp(8'h62), c + 2); rx_pulse(8'h62, 1);
    c = cyc; push_exp(echo_exp(8'h0D), c + 2); rx_pulse(8'h0D, 3);
    tick(4);
    chk("echo_ovf",   32'(ovf), 0);
    chk("echo_drain", exp_q.size(), 0);

    // Overflow: first byte parks in the output register, four fill the FIFO.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) rx_pulse(8'(8'h10 + i), 1);
    tick(2);
    chk("ovf_set",       32'(ovf),      1);
    chk("ovf_tx_valid",  32'(tx_valid), 1);
    chk("ovf_tx_data",   32'(tx_data),  32'h10);
    chk("ovf_busy",      32'(busy),     1);
    for (int i = 0; i < 5; i++) push_exp(8'(8'h10 + i), -1);
    base = n_xfer;
    tx_ready = 1'b1;
    wait_xfer(base + 5, 20);
    tick(3);
    chk("ovf_count", n_xfer - base, 5);
    chk("ovf_drain", exp_q.size(), 0);

    // Send: two bursts, mode drops at byte 5 of the second.
    c = cyc;
    mode = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) push_exp(msg_byte(i), c + 34 + i);
    base = n_xfer;
    wait_xfer(base + MSG_LEN, 60);
    for (int i = 0; i < MSG_LEN; i++) push_exp(msg_byte(i), c + 66 + i);
    while (cyc < c + 71) tick(1);
    mode = 1'b0;
    tick(2);
    rx_pulse(8'h55, 1);
    wait_xfer(base + 2*MSG_LEN, 40);
    tick(3);
    c = cyc; push_exp(echo_exp(8'h33), c + 2); rx_pulse(8'h33, 1);
    tick(3);
    chk("switch_drain", exp_q.size(), 0);

    // Send under pseudo-random backpressure (never two idle cycles in a row).
    mode = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) push_exp(msg_byte(i), -1);
    base = n_xfer;
    prev_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (n_xfer >= base + 1) mode = 1'b0;
      if (n_xfer >= base + MSG_LEN) break;
      tx_ready = prev_low ? 1'b1 : ($urandom_range(0, 1) == 1);
      prev_low = !tx_ready;
      tick(1);
    end
    chk("bp_count", n_xfer - base, MSG_LEN);
    tx_ready = 1'b1;
    tick(5);
    chk("bp_busy",  32'(busy), 0);
    chk("bp_drain", exp_q.size(), 0);

    // Reset while byte 7 is on the output; next burst restarts at 'H'.
    c = cyc;
    mode = 1'b1;
    for (int i = 0; i < 7; i++) push_exp(msg_byte(i), c + 34 + i);
    while (cyc < c + 41) tick(1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_tx_data",  32'(tx_data),  0);
    chk("mid_rst_ovf",      32'(ovf),      0);
    chk("mid_rst_busy",     32'(busy),     0);
    chk("mid_rst_drain",    exp_q.size(),  0);
    tick(2);
    rst = 1'b0;
    c = cyc;
    for (int i = 0; i < MSG_LEN; i++) push_exp(msg_byte(i), c + 34 + i);
    base = n_xfer;
    wait_xfer(base + 1, 60);
    mode = 1'b0;
    wait_xfer(base + MSG_LEN, 40);
    tick(3);
    chk("post_rst_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
